// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op indices, FSM encodings and SRAM packing helpers for the execute stage.
package ex_stage_pkg;

  localparam int IS_TO_ES_BUS_WD      = 192;
  localparam int ES_TO_MS_BUS_WD      = 76;
  localparam int ES_TO_IS_FORWARD_BUS = 38;
  localparam int ES_TO_HAZARD_BUS_WD  = 6;
  localparam int ALU_OP_WD            = 19;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  localparam int OP_RSVD_LO = 12;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_CANCEL = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Field order matches the issue-stage bus, MSB first.
  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 res_from_mem;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [31:0]          rj;
    logic [31:0]          rkd;
    logic [1:0]           st_size;
    logic                 unsigned_ld;
    logic [31:0]          imm;
    logic [31:0]          retpc;
    logic [31:0]          pc;
  } is_to_es_t;

  function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] lo2);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << lo2;
      SIZE_HALF: strb = lo2[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Narrow stores replicate the data so every lane carries the right bytes.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SIZE_BYTE: wd = {4{data[7:0]}};
      SIZE_HALF: wd = {2{data[15:0]}};
      default:   wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational one-hot ALU; any reserved op bit forces a zero result.
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          src1,
  input  logic [31:0]          src2,
  output logic [31:0]          result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] and_res;
  logic [31:0] nor_res;
  logic [31:0] or_res;
  logic [31:0] xor_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] lui_res;
  logic [31:0] onehot_res;
  logic        rsvd_set;

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign and_res  = src1 & src2;
  assign nor_res  = ~(src1 | src2);
  assign or_res   = src1 | src2;
  assign xor_res  = src1 ^ src2;
  assign sll_res  = src1 << src2[4:0];
  assign srl_res  = src1 >> src2[4:0];
  assign sra_res  = $unsigned($signed(src1) >>> src2[4:0]);
  assign lui_res  = src2;

  assign onehot_res = ({32{alu_op[OP_ADD]}}  & add_res)
                    | ({32{alu_op[OP_SUB]}}  & sub_res)
                    | ({32{alu_op[OP_SLT]}}  & slt_res)
                    | ({32{alu_op[OP_SLTU]}} & sltu_res)
                    | ({32{alu_op[OP_AND]}}  & and_res)
                    | ({32{alu_op[OP_NOR]}}  & nor_res)
                    | ({32{alu_op[OP_OR]}}   & or_res)
                    | ({32{alu_op[OP_XOR]}}  & xor_res)
                    | ({32{alu_op[OP_SLL]}}  & sll_res)
                    | ({32{alu_op[OP_SRL]}}  & srl_res)
                    | ({32{alu_op[OP_SRA]}}  & sra_res)
                    | ({32{alu_op[OP_LUI]}}  & lui_res);

  assign rsvd_set = |alu_op[ALU_OP_WD-1:OP_RSVD_LO];
  assign result   = rsvd_set ? 32'b0 : onehot_res;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: latches an issued instruction, runs the ALU and drives the data-SRAM request,
// with a small FSM that lets a flushed instruction's outstanding request drain safely.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            es_flush,
  input  logic                            is_to_es_valid,
  input  logic [IS_TO_ES_BUS_WD-1:0]      is_to_es_bus,
  output logic                            es_allowin,
  input  logic                            ms_allowin,
  output logic                            es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]      es_to_ms_bus,
  output logic [ES_TO_IS_FORWARD_BUS-1:0] es_to_is_forward_bus,
  output logic [ES_TO_HAZARD_BUS_WD-1:0]  es_to_hazard_bus,
  output logic                            es_cancel_resp,
  output logic                            data_sram_req,
  output logic                            data_sram_wr,
  output logic [1:0]                      data_sram_size,
  output logic [3:0]                      data_sram_wstrb,
  output logic [31:0]                     data_sram_addr,
  output logic [31:0]                     data_sram_wdata,
  input  logic                            data_sram_addr_ok
);

  logic        es_valid;
  is_to_es_t   es_bus;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        es_ready_go;
  logic        es_mem;
  logic        sram_req;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] es_result;
  logic [31:0] unused_retpc;

  assign es_mem       = es_bus.mem_we | es_bus.res_from_mem;
  assign src1         = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj;
  assign src2         = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd;
  assign unused_retpc = es_bus.retpc;

  alu u_alu (
    .alu_op (es_bus.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (es_result)
  );

  // Request FSM. REQ and CANCEL hold the request regardless of ms_allowin so the
  // memory handshake always completes; CANCEL does it on behalf of a flushed inst.
  always_comb begin
    sram_req       = 1'b0;
    es_ready_go    = 1'b1;
    es_cancel_resp = 1'b0;
    state_nxt      = state;
    case (state)
      ST_IDLE: begin
        sram_req    = es_valid & es_mem & ms_allowin & ~es_flush;
        es_ready_go = ~es_mem | (sram_req & data_sram_addr_ok);
        if (sram_req && !data_sram_addr_ok) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        sram_req    = 1'b1;
        es_ready_go = data_sram_addr_ok;
        if (data_sram_addr_ok) begin
          es_cancel_resp = es_flush;
          state_nxt      = (es_flush || ms_allowin) ? ST_IDLE : ST_DONE;
        end else if (es_flush) begin
          state_nxt = ST_CANCEL;
        end
      end
      ST_DONE: begin
        es_ready_go = 1'b1;
        if (es_flush || ms_allowin) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        sram_req    = 1'b1;
        es_ready_go = 1'b0;
        if (data_sram_addr_ok) begin
          es_cancel_resp = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
    endcase
  end

  assign es_allowin     = (state != ST_CANCEL) && (!es_valid || (es_ready_go && ms_allowin));
  assign es_to_ms_valid = es_valid & es_ready_go & ~es_flush;

  // A flush wins over a same-cycle capture; the upstream stage is flushed alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_bus   <= '0;
      state    <= ST_IDLE;
    end else begin
      state <= state_nxt;
      if (es_flush) begin
        es_valid <= 1'b0;
      end else if (es_allowin) begin
        es_valid <= is_to_es_valid;
      end
      if (!es_flush && es_allowin && is_to_es_valid) begin
        es_bus <= is_to_es_bus;
      end
    end
  end

  assign es_to_ms_bus = {es_bus.res_from_mem, es_bus.gr_we, es_bus.dest, es_bus.st_size,
                         es_bus.unsigned_ld, es_result[1:0], es_result, es_bus.pc};

  assign es_to_is_forward_bus = {ES_TO_IS_FORWARD_BUS{es_valid}}
                              & {es_bus.gr_we, es_bus.dest, es_result};
  assign es_to_hazard_bus     = {ES_TO_HAZARD_BUS_WD{es_valid}}
                              & {es_bus.res_from_mem, es_bus.dest};

  // SRAM fields are only driven while a request is up; the stage register keeps them stable.
  assign data_sram_req   = sram_req;
  assign data_sram_wr    = sram_req & es_bus.mem_we;
  assign data_sram_size  = sram_req ? es_bus.st_size : 2'b00;
  assign data_sram_addr  = sram_req ? es_result : 32'b0;
  assign data_sram_wstrb = (sram_req && es_bus.mem_we) ? store_wstrb(es_bus.st_size, es_result[1:0]) : 4'b0;
  assign data_sram_wdata = (sram_req && es_bus.mem_we) ? store_wdata(es_bus.st_size, es_bus.rkd) : 32'b0;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected MS-bus words go into a scoreboard queue at issue
// and are matched whenever the stage hands an instruction to MS.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_flush;
  logic         is_to_es_valid;
  logic [191:0] is_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [75:0]  es_to_ms_bus;
  logic [37:0]  es_to_is_forward_bus;
  logic [5:0]   es_to_hazard_bus;
  logic         es_cancel_resp;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [75:0]  sb[$];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .es_flush             (es_flush),
    .is_to_es_valid       (is_to_es_valid),
    .is_to_es_bus         (is_to_es_bus),
    .es_allowin           (es_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .es_to_is_forward_bus (es_to_is_forward_bus),
    .es_to_hazard_bus     (es_to_hazard_bus),
    .es_cancel_resp       (es_cancel_resp),
    .data_sram_req        (data_sram_req),
    .data_sram_wr         (data_sram_wr),
    .data_sram_size       (data_sram_size),
    .data_sram_wstrb      (data_sram_wstrb),
    .data_sram_addr       (data_sram_addr),
    .data_sram_wdata      (data_sram_wdata),
    .data_sram_addr_ok    (data_sram_addr_ok)
  );

  function automatic logic [191:0] make_bus(
    input logic [18:0] op, input logic s1pc, input logic s2imm, input logic rfm,
    input logic gwe, input logic mwe, input logic [4:0] dest, input logic [31:0] rj,
    input logic [31:0] rkd, input logic [1:0] sz, input logic uld, input logic [31:0] imm,
    input logic [31:0] pc);
    return {op, s1pc, s2imm, rfm, gwe, mwe, dest, rj, rkd, sz, uld, imm, 32'hDEAD0000, pc};
  endfunction

  function automatic logic [75:0] exp_ms(
    input logic rfm, input logic gwe, input logic [4:0] dest, input logic [1:0] sz,
    input logic uld, input logic [31:0] res, input logic [31:0] pc);
    return {rfm, gwe, dest, sz, uld, res[1:0], res, pc};
  endfunction

  task automatic checkOutput(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; returns #1 after the capturing edge.
  task automatic applyStimulus(input logic [191:0] bus);
    is_to_es_valid = 1'b1;
    is_to_es_bus   = bus;
    tick();
    is_to_es_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && es_to_ms_valid && ms_allowin) begin
      checkOutput("sb_has_entry", 76'(sb.size() != 0), 76'd1);
      if (sb.size() != 0) checkOutput("es_to_ms_bus", es_to_ms_bus, sb.pop_front());
    end
  end

  logic [18:0] tab_op  [0:12] = '{19'h2, 19'h4, 19'h8, 19'h10, 19'h20, 19'h40, 19'h80,
                                  19'h100, 19'h200, 19'h400, 19'h800, 19'h1001, 19'h1};
  logic [31:0] tab_exp [0:12] = '{32'hFFFFFFED, 32'h1, 32'h0, 32'h0, 32'h0000000C,
                                  32'hFFFFFFF3, 32'hFFFFFFF3, 32'hFFFFFF80, 32'h1FFFFFFE,
                                  32'hFFFFFFFE, 32'h12345000, 32'h0, 32'h2E345130};

  initial begin
    logic [191:0] b;
    logic [31:0]  pc;
    reset = 1'b1; es_flush = 1'b0; is_to_es_valid = 1'b0; is_to_es_bus = '0;
    ms_allowin = 1'b1; data_sram_addr_ok = 1'b0;
    $display("[TB] starting");
    repeat (2) @(negedge clk);
    checkOutput("rst_ms_valid", 76'(es_to_ms_valid), 76'd0);
    checkOutput("rst_req", 76'(data_sram_req), 76'd0);
    checkOutput("rst_fwd", 76'(es_to_is_forward_bus), 76'd0);
    checkOutput("rst_hazard", 76'(es_to_hazard_bus), 76'd0);
    checkOutput("rst_cancel", 76'(es_cancel_resp), 76'd0);
    checkOutput("rst_ms_bus", es_to_ms_bus, 76'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("allowin_after_rst", 76'(es_allowin), 76'd1);
    tick();

    // add rj=5, imm=7
    pc = 32'h1C000000;
    sb.push_back(exp_ms(0, 1, 5'd3, 2'b00, 0, 32'd12, pc));
    applyStimulus(make_bus(19'h1, 0, 1, 0, 1, 0, 5'd3, 32'd5, 32'd99, 2'b00, 0, 32'd7, pc));
    @(negedge clk);
    checkOutput("add_fwd", 76'(es_to_is_forward_bus), 76'({1'b1, 5'd3, 32'd12}));
    checkOutput("add_ms_valid", 76'(es_to_ms_valid), 76'd1);
    checkOutput("add_no_req", 76'(data_sram_req), 76'd0);
    tick();

    // ALU op table issued back to back
    for (int i = 0; i < 13; i++) begin
      pc = 32'h1C000100 + 32'(4 * i);
      sb.push_back(exp_ms(0, 1, 5'(10 + i), 2'b00, 0, tab_exp[i], pc));
      applyStimulus(make_bus(tab_op[i], i == 12, (i == 10) || (i == 12), 0, 1, 0, 5'(10 + i),
                             32'hFFFFFFF0, 32'h3, 2'b00, 0, 32'h12345000, pc));
    end
    @(negedge clk);
    tick();
    checkOutput("alu_drained", 76'(sb.size()), 76'd0);

    // st.b at 0x1003
    pc = 32'h1C000200;
    sb.push_back(exp_ms(0, 0, 5'd0, 2'b00, 0, 32'h1003, pc));
    applyStimulus(make_bus(19'h1, 0, 1, 0, 0, 1, 5'd0, 32'h1000, 32'hAB, 2'b00, 0, 32'd3, pc));
    @(negedge clk);
    checkOutput("stb_req", 76'(data_sram_req), 76'd1);
    checkOutput("stb_wr", 76'(data_sram_wr), 76'd1);
    checkOutput("stb_size", 76'(data_sram_size), 76'd0);
    checkOutput("stb_wstrb", 76'(data_sram_wstrb), 76'b1000);
    checkOutput("stb_wdata", 76'(data_sram_wdata), 76'hABABABAB);
    checkOutput("stb_addr", 76'(data_sram_addr), 76'h1003);
    checkOutput("stb_wait_valid", 76'(es_to_ms_valid), 76'd0);
    tick();
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("stb_req_held", 76'(data_sram_req), 76'd1);
    checkOutput("stb_ms_valid", 76'(es_to_ms_valid), 76'd1);
    tick();
    data_sram_addr_ok = 1'b0;

    // ld.w with addr_ok three cycles late
    pc = 32'h1C000300;
    sb.push_back(exp_ms(1, 1, 5'd7, 2'b10, 0, 32'h2008, pc));
    applyStimulus(make_bus(19'h1, 0, 1, 1, 1, 0, 5'd7, 32'h2000, 32'h0, 2'b10, 0, 32'd8, pc));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("ldw_req", 76'({data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb}),
                  76'({1'b1, 1'b0, 2'b10, 4'b0000}));
      checkOutput("ldw_addr", 76'(data_sram_addr), 76'h2008);
      checkOutput("ldw_no_valid", 76'(es_to_ms_valid), 76'd0);
      checkOutput("ldw_hazard", 76'(es_to_hazard_bus), 76'({1'b1, 5'd7}));
      tick();
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("ldw_ms_valid", 76'(es_to_ms_valid), 76'd1);
    checkOutput("ldw_hazard_ok", 76'(es_to_hazard_bus), 76'({1'b1, 5'd7}));
    tick();
    data_sram_addr_ok = 1'b0;

    // ALU op stalled by ms_allowin=0 for 2 cycles, next inst waiting in IS
    sb.push_back(exp_ms(0, 1, 5'd4, 2'b00, 0, 32'd123, 32'h1C000400));
    applyStimulus(make_bus(19'h1, 0, 1, 0, 1, 0, 5'd4, 32'd100, 32'd0, 2'b00, 0, 32'd23, 32'h1C000400));
    ms_allowin = 1'b0;
    is_to_es_valid = 1'b1;
    is_to_es_bus = make_bus(19'h2, 0, 0, 0, 1, 0, 5'd5, 32'd50, 32'd8, 2'b00, 0, 32'd0, 32'h1C000404);
    sb.push_back(exp_ms(0, 1, 5'd5, 2'b00, 0, 32'd42, 32'h1C000404));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("stall_allowin", 76'(es_allowin), 76'd0);
      checkOutput("stall_result", 76'(es_to_ms_bus[63:32]), 76'd123);
      tick();
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    checkOutput("stall_release", 76'(es_allowin), 76'd1);
    tick();
    is_to_es_valid = 1'b0;
    @(negedge clk);
    checkOutput("stall_next_result", 76'(es_to_ms_bus[63:32]), 76'd42);
    tick();

    // st.h accepted while ms_allowin=0, parks in DONE
    pc = 32'h1C000500;
    sb.push_back(exp_ms(0, 0, 5'd0, 2'b01, 0, 32'h3002, pc));
    applyStimulus(make_bus(19'h1, 0, 1, 0, 0, 1, 5'd0, 32'h3000, 32'h1234ABCD, 2'b01, 0, 32'd2, pc));
    @(negedge clk);
    checkOutput("sth_wstrb", 76'(data_sram_wstrb), 76'b1100);
    checkOutput("sth_wdata", 76'(data_sram_wdata), 76'hABCDABCD);
    checkOutput("sth_size", 76'(data_sram_size), 76'b01);
    tick();
    ms_allowin = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("sth_req_kept", 76'(data_sram_req), 76'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("done_no_req", 76'(data_sram_req), 76'd0);
    checkOutput("done_ms_valid", 76'(es_to_ms_valid), 76'd1);
    checkOutput("done_allowin", 76'(es_allowin), 76'd0);
    tick();
    ms_allowin = 1'b1;
    @(negedge clk);
    tick();

    // flush in REQ, addr_ok two cycles later
    applyStimulus(make_bus(19'h1, 0, 1, 1, 1, 0, 5'd9, 32'h2100, 32'h0, 2'b10, 0, 32'd4, 32'h1C000600));
    tick();
    es_flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_ms_valid", 76'(es_to_ms_valid), 76'd0);
    tick();
    es_flush = 1'b0;
    @(negedge clk);
    checkOutput("cancel_req", 76'(data_sram_req), 76'd1);
    checkOutput("cancel_addr", 76'(data_sram_addr), 76'h2104);
    checkOutput("cancel_allowin", 76'(es_allowin), 76'd0);
    checkOutput("cancel_hazard", 76'(es_to_hazard_bus), 76'd0);
    checkOutput("cancel_fwd", 76'(es_to_is_forward_bus), 76'd0);
    checkOutput("cancel_no_resp", 76'(es_cancel_resp), 76'd0);
    tick();
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("cancel_resp", 76'(es_cancel_resp), 76'd1);
    checkOutput("cancel_allowin2", 76'(es_allowin), 76'd0);
    tick();
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("cancel_resp_end", 76'(es_cancel_resp), 76'd0);
    checkOutput("cancel_idle_req", 76'(data_sram_req), 76'd0);
    checkOutput("cancel_idle_allow", 76'(es_allowin), 76'd1);
    tick();

    // flush coinciding with addr_ok in REQ
    applyStimulus(make_bus(19'h1, 0, 1, 1, 1, 0, 5'd11, 32'h2200, 32'h0, 2'b10, 0, 32'd0, 32'h1C000700));
    tick();
    es_flush = 1'b1;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("flushok_resp", 76'(es_cancel_resp), 76'd1);
    checkOutput("flushok_ms_valid", 76'(es_to_ms_valid), 76'd0);
    tick();
    es_flush = 1'b0;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("flushok_idle", 76'({data_sram_req, es_allowin, es_cancel_resp}), 76'b010);
    tick();

    // reset asserted mid-REQ
    applyStimulus(make_bus(19'h1, 0, 1, 1, 1, 0, 5'd12, 32'h5000, 32'h0, 2'b10, 0, 32'd0, 32'h1C000800));
    @(negedge clk);
    checkOutput("prerst_req", 76'(data_sram_req), 76'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_req", 76'(data_sram_req), 76'd0);
    checkOutput("midrst_ms_valid", 76'(es_to_ms_valid), 76'd0);
    checkOutput("midrst_hazard", 76'(es_to_hazard_bus), 76'd0);
    tick();
    reset = 1'b0;
    pc = 32'h1C000900;
    sb.push_back(exp_ms(1, 1, 5'd13, 2'b10, 0, 32'h4004, pc));
    applyStimulus(make_bus(19'h1, 0, 1, 1, 1, 0, 5'd13, 32'h4000, 32'h0, 2'b10, 0, 32'd4, pc));
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("postrst_req", 76'(data_sram_req), 76'd1);
    checkOutput("postrst_ms_valid", 76'(es_to_ms_valid), 76'd1);
    tick();
    data_sram_addr_ok = 1'b0;
    @(negedge clk);

    checkOutput("sb_empty", 76'(sb.size()), 76'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
